// File: rtl/bp_cce_inv_sender.sv
// Invalidation fan-out engine: walks the latched sharer set lowest-first and
// issues one e_lce_cmd_inv header per sharer, counting what went out.
module bp_cce_inv_sender #(
  parameter int num_lce_p       = 4,
  parameter int lce_assoc_p     = 8,
  parameter int paddr_width_p   = 40,
  parameter int lce_id_width_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  parameter int way_width_lp    = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  parameter int cnt_width_lp    = $clog2(num_lce_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              start_v_i,
  input  logic [paddr_width_p-1:0]          paddr_i,
  input  logic [lce_id_width_lp-1:0]        req_lce_id_i,
  input  logic [num_lce_p-1:0]              sharers_hits_i,
  input  logic [num_lce_p*way_width_lp-1:0] sharers_ways_i,
  output logic                              busy_o,
  output logic                              lce_cmd_v_o,
  input  logic                              lce_cmd_ready_i,
  output logic [lce_id_width_lp-1:0]        lce_cmd_dst_o,
  output logic [paddr_width_p-1:0]          lce_cmd_addr_o,
  output logic [way_width_lp-1:0]           lce_cmd_way_o,
  output logic                              done_o,
  output logic [cnt_width_lp-1:0]           inv_cnt_o,
  output logic [1:0]                        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [num_lce_p-1:0]                pend_q, pend_d;
  logic [num_lce_p*way_width_lp-1:0]   ways_q, ways_d;
  logic [paddr_width_p-1:0]            paddr_q, paddr_d;
  logic [cnt_width_lp-1:0]             cnt_q, cnt_d;

  logic [lce_id_width_lp-1:0]          dst;
  logic [way_width_lp-1:0]             way;
  logic [num_lce_p-1:0]                start_pend;
  logic [num_lce_p-1:0]                pend_clr;

  // Lowest set pending bit wins; header fields come only from registers.
  always_comb begin
    dst = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) begin
      if (pend_q[i]) dst = lce_id_width_lp'(i);
    end
    way = '0;
    for (int i = 0; i < num_lce_p; i++) begin
      if (dst == lce_id_width_lp'(i)) way = ways_q[i*way_width_lp +: way_width_lp];
    end
  end

  // A requester id outside the LCE range matches no bit, so nothing is excluded.
  always_comb begin
    for (int i = 0; i < num_lce_p; i++) begin
      start_pend[i] = sharers_hits_i[i] && (req_lce_id_i != lce_id_width_lp'(i));
      pend_clr[i]   = pend_q[i] && (dst != lce_id_width_lp'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ways_d  = ways_q;
    paddr_d = paddr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_v_i) begin
          pend_d  = start_pend;
          ways_d  = sharers_ways_i;
          paddr_d = paddr_i;
          cnt_d   = '0;
          state_d = (start_pend != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (lce_cmd_ready_i) begin
          pend_d  = pend_clr;
          cnt_d   = cnt_q + cnt_width_lp'(1);
          if (pend_clr == '0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ways_q  <= '0;
      paddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ways_q  <= ways_d;
      paddr_q <= paddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign lce_cmd_v_o    = (state_q == S_SEND);
  assign done_o         = (state_q == S_DONE);
  assign lce_cmd_dst_o  = dst;
  assign lce_cmd_way_o  = way;
  assign lce_cmd_addr_o = paddr_q;
  assign inv_cnt_o      = cnt_q;
  assign dbg_state_o    = state_q;

endmodule
